rvfi_imem_responder: RTL and testbench

RVFI_IMEM_RESPONDER -- requirements
Module: rvfi_imem_responder

---
 rtl/rvfi_imem_pkg.sv | 27 ++
 rtl/rvfi_imem_responder_if.sv | 29 ++
 rtl/rvfi_imem_fifo.sv | 78 +++++++
 rtl/rvfi_imem_responder.sv | 87 ++++++++
 tb/tb_rvfi_imem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_imem_pkg.sv
// Shared definitions for the RVFI instruction-memory responder.
//   LATENCY_MIN/LATENCY_MAX : legal range of the response latency parameter
//   PARCEL_W / INSN_W       : widths of one instruction parcel and one fetched word
//   AGE_W                   : width of a per-entry age counter (covers LATENCY_MAX)
//   fetch_word_t            : captured response payload (insn, err); the top pairs it
//                             with the XLEN-wide request address to form a queue entry
package rvfi_imem_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;
    localparam int unsigned PARCEL_W    = 16;
    localparam int unsigned INSN_W      = 32;
    localparam int unsigned AGE_W       = $clog2(LATENCY_MAX + 1);

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic              err;
    } fetch_word_t;

    // Substitute the constrained parcel when the address matches, else use fill data.
    function automatic logic [PARCEL_W-1:0] pick_parcel(input logic                hit,
                                                        input logic [PARCEL_W-1:0] imem_data,
                                                        input logic [PARCEL_W-1:0] fill);
        return hit ? imem_data : fill;
    endfunction

endpackage

// File: rtl/rvfi_imem_responder_if.sv
// Fetch request/response bus between a core (master) and the responder (slave).
//   req_valid/req_ready/req_addr          : fetch request handshake
//   rsp_valid/rsp_ready                   : response handshake
//   rsp_addr/rsp_insn/rsp_err             : response payload (0 while rsp_valid is low)
interface rvfi_imem_responder_if #(
    parameter int unsigned XLEN = 32
) ();
    import rvfi_imem_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [XLEN-1:0]     req_addr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_addr;
    logic [INSN_W-1:0]   rsp_insn;
    logic                rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_insn, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_insn, rsp_err
    );

endinterface

// File: rtl/rvfi_imem_fifo.sv
// In-order queue of DEPTH entries, each carrying an age counter.
//   clk, resetn      : clock, asynchronous active-low reset
//   push, push_data  : enqueue request (ignored while full)
//   full             : DEPTH entries outstanding
//   pop              : dequeue the head (ignored unless head_valid)
//   head_valid       : head present and its age has reached LATENCY
//   head_data        : head payload
module rvfi_imem_fifo
    import rvfi_imem_pkg::*;
#(
    parameter int unsigned WIDTH   = 65,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AGE_W-1:0] age_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign head_valid = (cnt_q != '0) && (age_q[rd_ptr_q] == AGE_W'(LATENCY));
    assign head_data  = mem[rd_ptr_q];
    assign do_push    = push && !full;
    assign do_pop     = pop && head_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Ages of empty slots tick too; harmless since a push restarts the slot at 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (do_push && (wr_ptr_q == PTR_W'(i))) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != AGE_W'(LATENCY)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind head_valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/rvfi_imem_responder.sv
// Formal-style instruction-memory responder: answers fetches after LATENCY cycles, in order,
// substituting the constrained parcel (imem_addr/imem_data) and filling all other parcels
// from free_data.
//   clk, resetn          : clock, asynchronous active-low reset
//   imem_addr, imem_data : constrained parcel address (bit 0 always 0) and its value
//   free_data            : fill data for every unconstrained parcel
//   bus (slave)          : request/response handshake and response payload
module rvfi_imem_responder
    import rvfi_imem_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [XLEN-1:0]     imem_addr,
    input  logic [PARCEL_W-1:0] imem_data,
    input  logic [INSN_W-1:0]   free_data,
    rvfi_imem_responder_if.slave bus
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("LATENCY out of range");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [XLEN-1:0] addr;
        fetch_word_t     word;
    } rsp_entry_t;

    logic            ready_en_q;
    logic            fifo_full;
    logic            head_valid;
    logic            accept;
    logic [XLEN-1:0] addr_plus2;
    logic            misaligned;
    logic            lo_hit;
    logic            hi_hit;
    rsp_entry_t      new_entry;
    rsp_entry_t      head;

    // Holds req_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ready_en_q <= 1'b0;
        else         ready_en_q <= 1'b1;
    end

    assign bus.req_ready = ready_en_q && !fifo_full;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        // Wraps modulo 2^XLEN so the upper parcel of the last halfword hits address 0.
        addr_plus2          = bus.req_addr + XLEN'(2);
        misaligned          = bus.req_addr[0];
        lo_hit              = !misaligned && (bus.req_addr == imem_addr);
        hi_hit              = !misaligned && (addr_plus2 == imem_addr);
        new_entry.addr      = bus.req_addr;
        new_entry.word.err  = misaligned;
        new_entry.word.insn = {pick_parcel(hi_hit, imem_data, free_data[31:16]),
                               pick_parcel(lo_hit, imem_data, free_data[15:0])};
    end

    rvfi_imem_fifo #(
        .WIDTH   ($bits(rsp_entry_t)),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_data  (new_entry),
        .full       (fifo_full),
        .pop        (bus.rsp_ready),
        .head_valid (head_valid),
        .head_data  (head)
    );

    assign bus.rsp_valid = head_valid;
    assign bus.rsp_addr  = head_valid ? head.addr      : '0;
    assign bus.rsp_insn  = head_valid ? head.word.insn : '0;
    assign bus.rsp_err   = head_valid ? head.word.err  : 1'b0;

endmodule

// File: tb/tb_rvfi_imem_responder.sv
module tb_rvfi_imem_responder;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] insn;
        logic        err;
        longint      t_acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [31:0] free_data;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;
    logic   m_ready_en;
    exp_t   sb[$];

    rvfi_imem_responder_if #(.XLEN(XLEN)) bus ();

    rvfi_imem_responder #(
        .XLEN    (XLEN),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .free_data (free_data),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance is allowed from the first edge after reset release.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_ready_en <= 1'b0;
        else         m_ready_en <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a fetch of address a returns, straight from the parcel rules.
    function automatic exp_t model_fetch(input logic [31:0] a, input logic [31:0] ia,
                                         input logic [15:0] id, input logic [31:0] fd,
                                         input longint t);
        exp_t        e;
        logic [15:0] lo;
        logic [15:0] hi;
        longint      nxt;
        e.addr  = a;
        e.t_acc = t;
        if (a % 2 == 1) begin
            e.err  = 1'b1;
            e.insn = fd;
        end else begin
            nxt    = (longint'(a) + 2) % 64'h1_0000_0000;
            lo     = (a == ia) ? id : fd[15:0];
            hi     = (nxt == longint'(ia)) ? id : fd[31:16];
            e.err  = 1'b0;
            e.insn = {hi, lo};
        end
        return e;
    endfunction

    // Monitor / scoreboard: compares outputs every cycle, pops on handshake, pushes on accept.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                sb.delete();
                check("rst_req_ready", bus.req_ready, 0);
                check("rst_rsp_valid", bus.rsp_valid, 0);
                check("rst_rsp_addr", bus.rsp_addr, 0);
                check("rst_rsp_insn", bus.rsp_insn, 0);
                check("rst_rsp_err", bus.rsp_err, 0);
            end else begin
                logic exp_ready;
                logic exp_valid;
                exp_ready = m_ready_en && (sb.size() < DEPTH);
                exp_valid = (sb.size() > 0) && (cyc >= sb[0].t_acc + LATENCY);
                check("req_ready", bus.req_ready, exp_ready);
                check("rsp_valid", bus.rsp_valid, exp_valid);
                if (exp_valid) begin
                    check("rsp_addr", bus.rsp_addr, sb[0].addr);
                    check("rsp_insn", bus.rsp_insn, sb[0].insn);
                    check("rsp_err", bus.rsp_err, sb[0].err);
                    if (bus.rsp_ready) void'(sb.pop_front());
                end else begin
                    check("idle_rsp_addr", bus.rsp_addr, 0);
                    check("idle_rsp_insn", bus.rsp_insn, 0);
                    check("idle_rsp_err", bus.rsp_err, 0);
                end
                if (bus.req_valid && exp_ready) begin
                    sb.push_back(model_fetch(bus.req_addr, imem_addr, imem_data, free_data,
                                             cyc + 1));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL send_accept: got no req_ready within 50 cycles, expected accept");
        end
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int k;
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        imem_addr     = 32'h100;
        imem_data     = 16'hA5A5;
        free_data     = 32'h1234_5678;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Directed parcel cases.
        bus.rsp_ready = 1'b1;
        send(32'h0000_0100);
        send(32'h0000_00FE);
        send(32'h0000_0101);
        imem_addr = 32'h0;
        send(32'hFFFF_FFFE);
        imem_addr = 32'h500;
        imem_data = 16'h0F0F;
        free_data = 32'hDEAD_BEEF;
        repeat (6) step();

        // Fill with the core stalled, then drain while offering another request.
        imem_addr     = 32'h200;
        imem_data     = 16'h1111;
        bus.rsp_ready = 1'b0;
        send(32'h0000_0200);
        send(32'h0000_01FE);
        send(32'h0000_0203);
        send(32'h0000_0400);
        check("full_req_ready", bus.req_ready, 0);
        repeat (4) step();
        bus.rsp_ready = 1'b1;
        send(32'h0000_0202);
        repeat (8) step();

        // Reset with entries outstanding.
        bus.rsp_ready = 1'b0;
        send(32'h0000_0200);
        send(32'h0000_0204);
        send(32'h0000_0208);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_rsp_valid", bus.rsp_valid, 0);
        check("async_rst_req_ready", bus.req_ready, 0);
        step();
        step();
        resetn        = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (10) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            imem_addr = $urandom() & 32'hFFFF_FFFE;
            if ($urandom_range(0, 7) == 0) imem_addr = 32'h0;
            imem_data = 16'($urandom());
            free_data = $urandom();
            case ($urandom_range(0, 3))
                0:       bus.req_addr = imem_addr;
                1:       bus.req_addr = imem_addr - 32'd2;
                2:       bus.req_addr = $urandom() | 32'h1;
                default: bus.req_addr = $urandom() & 32'hFFFF_FFFE;
            endcase
            bus.req_valid = ($urandom_range(0, 9) < 6);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            step();
            k++;
        end
        check("drain_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
